lcd_rx_monitor: RTL and testbench

- Listening end of the HD44780-style 4-bit LCD bus that the LCD text sender drives: RS on LCD_D[4], nibble on LCD_D[3:0], latched on the falling edge of LCD_E.
- Rebuilds command and data bytes from the nibbles and tracks the controller mode and cursor.
- Mirrors the 2x16 display into a 32-byte character buffer that can be read back.
- Used as an on-chip loopback checker and as the bench's LCD model; shares the single system clock.

---
 rtl/lcd_rx_monitor_if.sv | 26 ++
 rtl/lcd_rx_monitor.sv | 270 +++++++++++++++++++++++++++
 tb/tb_lcd_rx_monitor.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_rx_monitor_if.sv
// Bus bundle between an HD44780-style 4-bit LCD driver and the receive monitor.
// The master drives the LCD pins and the read index; the slave (monitor) returns status.
interface lcd_rx_monitor_if;
    logic [4:0] lcd_d;       // [4]=RS, [3:0]=nibble
    logic       lcd_e;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_rs;
    logic [4:0] cursor;
    logic       cursor_ok;
    logic       mode4;
    logic       busy;
    logic       err;

    modport master (
        output lcd_d, lcd_e, rd_addr,
        input  rd_data, byte_valid, byte_data, byte_rs, cursor, cursor_ok, mode4, busy, err
    );

    modport slave (
        input  lcd_d, lcd_e, rd_addr,
        output rd_data, byte_valid, byte_data, byte_rs, cursor, cursor_ok, mode4, busy, err
    );
endinterface

// File: rtl/lcd_rx_monitor.sv
// Listens to a 4-bit HD44780 bus, rebuilds bytes, tracks mode and cursor, and mirrors
// the 2x16 display into a 32-byte readable character buffer.
module lcd_rx_monitor #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter logic [7:0]  CLEAR_CHAR     = 8'h20
) (
    input  logic            clk,
    input  logic            rst_n,
    lcd_rx_monitor_if.slave bus
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_INIT8,
        S_HI,
        S_LO
    } state_e;

    // ------------------------------------------------------------------
    // Input synchronizers and E falling-edge detect
    // ------------------------------------------------------------------
    logic [1:0] e_sync_q;
    logic       e_prev_q;
    logic [4:0] d_s1_q;
    logic [4:0] d_s2_q;
    logic       strobe;
    logic       strobe_rs;
    logic [3:0] strobe_nib;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_sync_q <= '0;
            e_prev_q <= 1'b0;
            d_s1_q   <= '0;
            d_s2_q   <= '0;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            e_sync_q <= {e_sync_q[0], bus.lcd_e};
            e_prev_q <= e_sync_q[1];
            d_s1_q   <= bus.lcd_d;
            d_s2_q   <= d_s1_q;
        end
    end

    assign strobe     = e_prev_q & ~e_sync_q[1];
    assign strobe_rs  = d_s2_q[4];
    assign strobe_nib = d_s2_q[3:0];

    // ------------------------------------------------------------------
    // Nibble assembly FSM
    // ------------------------------------------------------------------
    state_e        state_q, state_d;
    logic [3:0]    hi_nib_q, hi_nib_d;
    logic          hi_rs_q, hi_rs_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          mode4_q, mode4_d;
    logic          byte_valid_q, byte_valid_d;
    logic [7:0]    byte_data_q, byte_data_d;
    logic          byte_rs_q, byte_rs_d;
    logic          tmo_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_INIT8;
            hi_nib_q     <= '0;
            hi_rs_q      <= 1'b0;
            tmo_cnt_q    <= '0;
            mode4_q      <= 1'b0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= '0;
            byte_rs_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hi_nib_q     <= hi_nib_d;
            hi_rs_q      <= hi_rs_d;
            tmo_cnt_q    <= tmo_cnt_d;
            mode4_q      <= mode4_d;
            byte_valid_q <= byte_valid_d;
            byte_data_q  <= byte_data_d;
            byte_rs_q    <= byte_rs_d;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_d      = state_q;
        hi_nib_d     = hi_nib_q;
        hi_rs_d      = hi_rs_q;
        tmo_cnt_d    = tmo_cnt_q;
        mode4_d      = mode4_q;
        byte_valid_d = 1'b0;
        byte_data_d  = byte_data_q;
        byte_rs_d    = byte_rs_q;
        tmo_err      = 1'b0;

        unique case (state_q)
            S_INIT8: begin
                if (strobe) begin
                    byte_valid_d = 1'b1;
                    byte_data_d  = {strobe_nib, 4'h0};
                    byte_rs_d    = strobe_rs;
                    if (!strobe_rs && strobe_nib == 4'h2) begin
                        state_d = S_HI;
                        mode4_d = 1'b1;
                    end
                end
            end
            S_HI: begin
                if (strobe) begin
                    hi_nib_d  = strobe_nib;
                    hi_rs_d   = strobe_rs;
                    tmo_cnt_d = '0;
                    state_d   = S_LO;
                end
            end
            S_LO: begin
                if (strobe) begin
                    byte_valid_d = 1'b1;
                    byte_data_d  = {hi_nib_q, strobe_nib};
                    byte_rs_d    = hi_rs_q;
                    // An 8-bit function set drops the bus back to single-strobe commands.
                    if (!hi_rs_q && hi_nib_q == 4'h3) begin
                        state_d = S_INIT8;
                        mode4_d = 1'b0;
                    end else begin
                        state_d = S_HI;
                    end
                end else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    tmo_err = 1'b1;
                    state_d = S_HI;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            default: state_d = S_INIT8;
        endcase
    end

    // ------------------------------------------------------------------
    // Byte execution, pending slot and clear fill
    // ------------------------------------------------------------------
    logic       pend_valid_q, pend_valid_d;
    logic [8:0] pend_q, pend_d;            // {rs, byte}
    logic       busy_q, busy_d;
    logic [4:0] clr_idx_q, clr_idx_d;
    logic [4:0] cursor_q, cursor_d;        // {line, col}
    logic       cursor_ok_q, cursor_ok_d;
    logic       err_q, err_d;
    logic       ovr_err;
    logic       exec_valid;
    logic [7:0] exec_byte;
    logic       exec_rs;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_q <= 1'b0;
            pend_q       <= '0;
            busy_q       <= 1'b0;
            clr_idx_q    <= '0;
            cursor_q     <= '0;
            cursor_ok_q  <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_q       <= pend_d;
            busy_q       <= busy_d;
            clr_idx_q    <= clr_idx_d;
            cursor_q     <= cursor_d;
            cursor_ok_q  <= cursor_ok_d;
            err_q        <= err_d;
        end
    end

    // A held byte runs on the first idle cycle; otherwise the fresh byte runs directly.
    always_comb begin
        exec_valid   = 1'b0;
        exec_byte    = byte_data_q;
        exec_rs      = byte_rs_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        ovr_err      = 1'b0;

        if (!busy_q && pend_valid_q) begin
            exec_valid   = 1'b1;
            exec_byte    = pend_q[7:0];
            exec_rs      = pend_q[8];
            pend_valid_d = 1'b0;
        end else if (!busy_q && byte_valid_q) begin
            exec_valid = 1'b1;
        end

        if (byte_valid_q && (busy_q || pend_valid_q)) begin
            pend_d       = {byte_rs_q, byte_data_q};
            pend_valid_d = 1'b1;
            ovr_err      = busy_q && pend_valid_q;
        end
    end

    always_comb begin
        cursor_d    = cursor_q;
        cursor_ok_d = cursor_ok_q;
        busy_d      = busy_q;
        clr_idx_d   = clr_idx_q;
        wr_en       = 1'b0;
        wr_addr     = cursor_q;
        wr_data     = exec_byte;
        err_d       = err_q | tmo_err | ovr_err;

        if (busy_q) begin
            wr_en     = 1'b1;
            wr_addr   = clr_idx_q;
            wr_data   = CLEAR_CHAR;
            clr_idx_d = clr_idx_q + 5'd1;
            if (clr_idx_q == 5'd31) busy_d = 1'b0;
        end else if (exec_valid) begin
            if (exec_rs) begin
                // {line, col} + 1 wraps col 15 into the other line, line 2 back to line 1.
                if (cursor_ok_q) begin
                    wr_en    = 1'b1;
                    cursor_d = cursor_q + 5'd1;
                end
            end else if (exec_byte == 8'h01) begin
                cursor_d    = '0;
                cursor_ok_d = 1'b1;
                busy_d      = 1'b1;
                clr_idx_d   = '0;
            end else if (exec_byte[7:1] == 7'b0000001) begin
                cursor_d    = '0;
                cursor_ok_d = 1'b1;
            end else if (exec_byte[7]) begin
                cursor_d[4] = exec_byte[6];
                if (exec_byte[5:4] == 2'b00) begin
                    cursor_d[3:0] = exec_byte[3:0];
                    cursor_ok_d   = 1'b1;
                end else begin
                    cursor_ok_d = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Character buffer
    // ------------------------------------------------------------------
    logic [7:0] mem_q [32];
    logic [7:0] rd_data_q;

    // NOTE: the buffer array is deliberately not reset; only the clear command defines it.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data_q <= '0;
        else        rd_data_q <= mem_q[bus.rd_addr];
    end

    assign bus.rd_data    = rd_data_q;
    assign bus.byte_valid = byte_valid_q;
    assign bus.byte_data  = byte_data_q;
    assign bus.byte_rs    = byte_rs_q;
    assign bus.cursor     = cursor_q;
    assign bus.cursor_ok  = cursor_ok_q;
    assign bus.mode4      = mode4_q;
    assign bus.busy       = busy_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_lcd_rx_monitor.sv
// Directed bench for lcd_rx_monitor: a display-level model predicts bytes, cursor and buffer;
// a monitor process checks every completed byte and every clear-fill window.
`timescale 1ns/1ps
module tb_lcd_rx_monitor;
    localparam int unsigned TMO = 40;
    localparam logic [7:0]  CLR = 8'h20;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    lcd_rx_monitor_if bus ();

    lcd_rx_monitor #(
        .TIMEOUT_CYCLES(TMO),
        .CLEAR_CHAR    (CLR)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- display model ----------------
    logic [7:0] m_buf [32];
    logic       m_line;
    logic [3:0] m_col;
    logic       m_ok, m_mode4, m_err, m_busy_win, m_pend_valid;
    logic [8:0] m_pend;
    logic [8:0] exp_q [$];

    task automatic model_exec(input logic [7:0] b, input logic rs);
        if (rs) begin
            if (m_ok) begin
                m_buf[m_line * 16 + m_col] = b;
                if (m_col == 4'd15) begin
                    m_col  = 4'd0;
                    m_line = ~m_line;
                end else begin
                    m_col = m_col + 4'd1;
                end
            end
        end else if (b == 8'h01) begin
            for (int i = 0; i < 32; i++) m_buf[i] = CLR;
            m_line = 1'b0; m_col = 4'd0; m_ok = 1'b1;
            m_busy_win = 1'b1;
        end else if (b == 8'h02 || b == 8'h03) begin
            m_line = 1'b0; m_col = 4'd0; m_ok = 1'b1;
        end else if (b[7]) begin
            m_line = b[6];
            if (b[5:4] == 2'b00) begin
                m_col = b[3:0];
                m_ok  = 1'b1;
            end else begin
                m_ok = 1'b0;
            end
        end
    endtask

    task automatic model_apply(input logic [7:0] b, input logic rs);
        exp_q.push_back({rs, b});
        if (m_busy_win) begin
            if (m_pend_valid) m_err = 1'b1;
            m_pend       = {rs, b};
            m_pend_valid = 1'b1;
        end else begin
            model_exec(b, rs);
        end
    endtask

    // ---------------- compare process ----------------
    int bv_count = 0;
    int busy_run = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.byte_valid) begin
                logic [8:0] e;
                bv_count++;
                check("byte_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("byte_data", bus.byte_data, e[7:0]);
                    check("byte_rs", bus.byte_rs, e[8]);
                end
            end
            if (bus.busy) begin
                busy_run++;
            end else if (busy_run != 0) begin
                check("busy_width", busy_run, 32);
                busy_run = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_nib(input logic rs, input logic [3:0] nib);
        bus.lcd_d = {rs, nib};
        bus.lcd_e = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.lcd_e = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic send_init(input logic [3:0] nib);
        model_apply({nib, 4'h0}, 1'b0);
        if (nib == 4'h2) m_mode4 = 1'b1;
        send_nib(1'b0, nib);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic rs);
        model_apply(b, rs);
        send_nib(rs, b[7:4]);
        send_nib(rs, b[3:0]);
    endtask

    task automatic wait_idle();
        int n = 0;
        repeat (4) @(posedge clk);
        while (bus.busy && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("busy_ends_in_time", n < 100, 1'b1);
        if (m_busy_win) begin
            m_busy_win = 1'b0;
            if (m_pend_valid) begin
                m_pend_valid = 1'b0;
                model_exec(m_pend[7:0], m_pend[8]);
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic read_buf(input int idx, output logic [7:0] val);
        bus.rd_addr = 5'(idx);
        @(posedge clk);
        #1;
        val = bus.rd_data;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_cursor"},    bus.cursor, {m_line, m_col});
        check({tag, "_cursor_ok"}, bus.cursor_ok, m_ok);
        check({tag, "_mode4"},     bus.mode4, m_mode4);
        check({tag, "_err"},       bus.err, m_err);
        check({tag, "_busy"},      bus.busy, 1'b0);
    endtask

    task automatic check_buf(input string tag);
        logic [7:0] v;
        for (int i = 0; i < 32; i++) begin
            read_buf(i, v);
            check($sformatf("%s_buf%0d", tag, i), v, m_buf[i]);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_rd_data",    bus.rd_data, 8'h00);
        check("rst_byte_valid", bus.byte_valid, 1'b0);
        check("rst_byte_data",  bus.byte_data, 8'h00);
        check("rst_byte_rs",    bus.byte_rs, 1'b0);
        check("rst_cursor",     bus.cursor, 5'd0);
        check("rst_cursor_ok",  bus.cursor_ok, 1'b1);
        check("rst_mode4",      bus.mode4, 1'b0);
        check("rst_busy",       bus.busy, 1'b0);
        check("rst_err",        bus.err, 1'b0);
        m_line = 1'b0; m_col = 4'd0; m_ok = 1'b1; m_mode4 = 1'b0; m_err = 1'b0;
        m_busy_win = 1'b0; m_pend_valid = 1'b0; m_pend = '0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [7:0] v;
        int         bv_before;
        bus.lcd_d   = '0;
        bus.lcd_e   = 1'b0;
        bus.rd_addr = '0;
        for (int i = 0; i < 32; i++) m_buf[i] = '0;

        do_reset();

        // init handshake 3,3,3,2
        send_init(4'h3);
        send_init(4'h3);
        send_init(4'h3);
        send_init(4'h2);
        repeat (3) @(posedge clk);
        #1;
        check("init_mode4", bus.mode4, 1'b1);
        check("init_bytes", bv_count, 4);
        check_state("init");

        // clear
        send_byte(8'h01, 1'b0);
        wait_idle();
        check("clear_byte", bus.byte_data, 8'h01);
        check_buf("clear");

        // line wrap
        send_byte(8'h01, 1'b0);
        wait_idle();
        send_byte(8'h8E, 1'b0);
        send_byte(8'h41, 1'b1);
        send_byte(8'h42, 1'b1);
        send_byte(8'h43, 1'b1);
        wait_idle();
        check("wrap_cursor", bus.cursor, 5'd17);
        read_buf(14, v); check("wrap_buf14", v, 8'h41);
        read_buf(15, v); check("wrap_buf15", v, 8'h42);
        read_buf(16, v); check("wrap_buf16", v, 8'h43);
        check_state("wrap");

        // line 2 and off-screen address
        send_byte(8'hC0, 1'b0);
        send_byte(8'h78, 1'b1);
        wait_idle();
        read_buf(16, v); check("line2_buf16", v, 8'h78);
        send_byte(8'h94, 1'b0);
        send_byte(8'h79, 1'b1);
        wait_idle();
        check("offscreen_cursor_ok", bus.cursor_ok, 1'b0);
        check_state("offscreen");
        check_buf("offscreen");

        // lone high nibble then timeout
        bv_before = bv_count;
        send_nib(1'b1, 4'h7);
        repeat (TMO + 5) @(posedge clk);
        #1;
        m_err = 1'b1;
        check("timeout_err", bus.err, 1'b1);
        check("timeout_no_byte", bv_count, bv_before);
        send_byte(8'h41, 1'b1);
        wait_idle();
        check("after_timeout_byte", bus.byte_data, 8'h41);
        check("after_timeout_rs", bus.byte_rs, 1'b1);
        check_state("timeout");

        // fresh start, then two characters inside the clear window
        do_reset();
        send_init(4'h3);
        send_init(4'h3);
        send_init(4'h3);
        send_init(4'h2);
        send_byte(8'h01, 1'b0);
        send_byte(8'h50, 1'b1);
        send_byte(8'h51, 1'b1);
        wait_idle();
        check("overrun_err", bus.err, 1'b1);
        read_buf(0, v); check("overrun_buf0", v, 8'h51);
        read_buf(1, v); check("overrun_buf1", v, 8'h20);
        check_state("overrun");
        check_buf("overrun");

        check("all_bytes_seen", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
